// File: rtl/wb_unit.sv
// Writeback stage: captures completed instructions, waits for load data, drives the register-file write port.
// Optional combinational write-to-read bypass for operand fetch is enabled with `define WB_BYPASS_EN.
module wb_unit #(
  parameter int unsigned LD_TIMEOUT = 255,
  parameter int unsigned RA_REG     = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_isWb,
  input  logic        in_isLd,
  input  logic        in_isCall,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_aluResult,
  input  logic [31:0] in_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
`ifdef WB_BYPASS_EN
  input  logic [4:0]  RP1,
  input  logic [4:0]  RP2,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic [31:0] A_fwd,
  output logic [31:0] B_fwd,
`endif
  output logic        isWb,
  output logic [4:0]  WP,
  output logic [31:0] WriteData,
  output logic        ld_err
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ld_wb_q, ld_wb_d;
  logic [REG_W-1:0]    ld_rd_q, ld_rd_d;
  logic                is_wb_q, is_wb_d;
  logic [REG_W-1:0]    wp_q, wp_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                ld_err_q, ld_err_d;
  logic                accept;

  // Upstream is stalled only while a load is outstanding.
  assign in_ready = (state_q != WAIT_LD);
  assign accept   = in_valid & in_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_wb_d  = ld_wb_q;
    ld_rd_d  = ld_rd_q;
    is_wb_d  = 1'b0;
    wp_d     = wp_q;
    wd_d     = wd_q;
    ld_err_d = ld_err_q;

    unique case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          if (in_isLd) begin
            // A call flagged as a load is treated as a plain load.
            state_d = WAIT_LD;
            cnt_d   = '0;
            ld_wb_d = in_isWb;
            ld_rd_d = in_rd;
          end else begin
            state_d = WRITE;
            is_wb_d = in_isWb | in_isCall;
            wp_d    = in_isCall ? REG_W'(RA_REG) : in_rd;
            wd_d    = in_isCall ? (in_pc + DATA_W'(4)) : in_aluResult;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LD: begin
        // Load data takes priority over the timeout on the same cycle.
        if (ld_valid) begin
          state_d = WRITE;
          is_wb_d = ld_wb_q;
          wp_d    = ld_rd_q;
          wd_d    = ld_data;
        end else if (cnt_q == CNT_W'(LD_TIMEOUT)) begin
          state_d  = IDLE;
          ld_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ld_wb_q  <= 1'b0;
      ld_rd_q  <= '0;
      is_wb_q  <= 1'b0;
      wp_q     <= '0;
      wd_q     <= '0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_wb_q  <= ld_wb_d;
      ld_rd_q  <= ld_rd_d;
      is_wb_q  <= is_wb_d;
      wp_q     <= wp_d;
      wd_q     <= wd_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign isWb      = is_wb_q;
  assign WP        = wp_q;
  assign WriteData = wd_q;
  assign ld_err    = ld_err_q;

`ifdef WB_BYPASS_EN
  // Operand fetch sees the value being committed this cycle.
  assign A_fwd = (is_wb_q && (wp_q == RP1)) ? wd_q : regA;
  assign B_fwd = (is_wb_q && (wp_q == RP2)) ? wd_q : regB;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: a write-transaction scoreboard checked on every isWb cycle,
// plus hand-computed literal expectations at each step.
module tb_wb_unit;

  localparam int unsigned LD_TIMEOUT = 4;
  localparam int unsigned RA_REG     = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_isWb, in_isLd, in_isCall;
  logic [4:0]  in_rd;
  logic [31:0] in_aluResult, in_pc;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        isWb, ld_err;
  logic [4:0]  WP;
  logic [31:0] WriteData;
`ifdef WB_BYPASS_EN
  logic [4:0]  RP1, RP2;
  logic [31:0] regA, regB, A_fwd, B_fwd;
`endif

  wb_unit #(.LD_TIMEOUT(LD_TIMEOUT), .RA_REG(RA_REG)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_isWb(in_isWb), .in_isLd(in_isLd), .in_isCall(in_isCall),
    .in_rd(in_rd), .in_aluResult(in_aluResult), .in_pc(in_pc),
    .ld_valid(ld_valid), .ld_data(ld_data),
`ifdef WB_BYPASS_EN
    .RP1(RP1), .RP2(RP2), .regA(regA), .regB(regB), .A_fwd(A_fwd), .B_fwd(B_fwd),
`endif
    .isWb(isWb), .WP(WP), .WriteData(WriteData), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  wp;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a non-load instruction.
  function automatic wr_t alu_result(input logic isCall, input logic [4:0] rd,
                                     input logic [31:0] alu, input logic [31:0] pc);
    wr_t r;
    r.wp = isCall ? 5'(RA_REG) : rd;
    r.wd = isCall ? pc + 32'd4 : alu;
    return r;
  endfunction

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b0 && isWb === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wb", 32'(isWb), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_wp", 32'(WP), 32'(e.wp));
        chk("sb_data", WriteData, e.wd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_isWb = 1'b0; in_isLd = 1'b0; in_isCall = 1'b0;
    in_rd = '0; in_aluResult = '0; in_pc = '0;
    ld_valid = 1'b0; ld_data = '0;
  endtask

  // Present one instruction for one edge; it must be accepted.
  task automatic send(input logic wb, input logic ld, input logic call,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc);
    in_valid = 1'b1; in_isWb = wb; in_isLd = ld; in_isCall = call;
    in_rd = rd; in_aluResult = alu; in_pc = pc;
    chk("ready_at_send", 32'(in_ready), 32'd1);
    if (!ld && (wb || call)) exp_q.push_back(alu_result(call, rd, alu, pc));
    step();
  endtask

  task automatic deliver(input logic [31:0] data, input logic [4:0] rd, input logic expect_wb);
    ld_valid = 1'b1; ld_data = data;
    if (expect_wb) exp_q.push_back('{wp: rd, wd: data});
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t m;
    idle_inputs();
`ifdef WB_BYPASS_EN
    RP1 = '0; RP2 = '0; regA = '0; regB = '0;
`endif
    do_reset();
    chk("rst_isWb", 32'(isWb), 32'd0);
    chk("rst_WP", 32'(WP), 32'd0);
    chk("rst_data", WriteData, 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Pin the model itself against hand-computed values.
    m = alu_result(1'b1, 5'd9, 32'h0, 32'h100);
    chk("model_call_wp", 32'(m.wp), 32'd31);
    chk("model_call_wd", m.wd, 32'h104);
    m = alu_result(1'b1, 5'd0, 32'h0, 32'hFFFF_FFFC);
    chk("model_call_wrap", m.wd, 32'h0);

    // ALU op: one-cycle pulse.
    send(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h40);
    idle_inputs();
    chk("alu_isWb", 32'(isWb), 32'd1);
    chk("alu_WP", 32'(WP), 32'd5);
    chk("alu_data", WriteData, 32'h1234);
    chk("alu_ready", 32'(in_ready), 32'd1);
    step();
    chk("alu_pulse_end", 32'(isWb), 32'd0);
    chk("alu_WP_hold", 32'(WP), 32'd5);
    chk("alu_data_hold", WriteData, 32'h1234);

    // Call writes pc+4 to the return-address register.
    send(1'b0, 1'b0, 1'b1, 5'd9, 32'hBAD0_BAD0, 32'h100);
    idle_inputs();
    chk("call_isWb", 32'(isWb), 32'd1);
    chk("call_WP", 32'(WP), 32'd31);
    chk("call_data", WriteData, 32'h104);
    step();

    // ld_valid outside a load must be ignored.
    ld_valid = 1'b1; ld_data = 32'h5555_5555;
    step();
    ld_valid = 1'b0;
    step();
    chk("stray_ld_isWb", 32'(isWb), 32'd0);

    // Load with data three cycles after acceptance.
    send(1'b1, 1'b1, 1'b0, 5'd7, 32'hBAD, 32'h0);
    idle_inputs();
    chk("ld_ready_low", 32'(in_ready), 32'd0);
    chk("ld_wait_isWb", 32'(isWb), 32'd0);
    step();
    step();
    chk("ld_ready_low2", 32'(in_ready), 32'd0);
    deliver(32'hDEAD_BEEF, 5'd7, 1'b1);
    chk("ld_isWb", 32'(isWb), 32'd1);
    chk("ld_WP", 32'(WP), 32'd7);
    chk("ld_data", WriteData, 32'hDEAD_BEEF);
    chk("ld_ready_back", 32'(in_ready), 32'd1);
    step();

    // Call flagged as load behaves as a load to in_rd.
    send(1'b1, 1'b1, 1'b1, 5'd6, 32'h0, 32'h200);
    idle_inputs();
    deliver(32'h77, 5'd6, 1'b1);
    chk("ldcall_WP", 32'(WP), 32'd6);
    chk("ldcall_data", WriteData, 32'h77);
    step();

    // Timeout: wait cycles with counter 0..LD_TIMEOUT, then abandon.
    send(1'b1, 1'b1, 1'b0, 5'd8, 32'h0, 32'h0);
    idle_inputs();
    for (int i = 0; i < int'(LD_TIMEOUT); i++) step();
    chk("to_err_not_yet", 32'(ld_err), 32'd0);
    chk("to_still_wait", 32'(in_ready), 32'd0);
    step();
    chk("to_err", 32'(ld_err), 32'd1);
    chk("to_idle", 32'(in_ready), 32'd1);
    chk("to_isWb", 32'(isWb), 32'd0);
    step();
    chk("to_err_sticky", 32'(ld_err), 32'd1);

    // Data on the timeout cycle wins.
    do_reset();
    chk("rst_clears_err", 32'(ld_err), 32'd0);
    send(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0);
    idle_inputs();
    for (int i = 0; i < int'(LD_TIMEOUT); i++) step();
    deliver(32'hCAFE_F00D, 5'd9, 1'b1);
    chk("edge_isWb", 32'(isWb), 32'd1);
    chk("edge_WP", 32'(WP), 32'd9);
    chk("edge_err", 32'(ld_err), 32'd0);
    step();

    // Back-to-back ALU ops.
    send(1'b1, 1'b0, 1'b0, 5'd1, 32'h11, 32'h0);
    chk("b2b_WP1", 32'(WP), 32'd1);
    send(1'b1, 1'b0, 1'b0, 5'd2, 32'h22, 32'h4);
    chk("b2b_WP2", 32'(WP), 32'd2);
    chk("b2b_isWb2", 32'(isWb), 32'd1);
    send(1'b1, 1'b0, 1'b0, 5'd3, 32'h33, 32'h8);
    idle_inputs();
    chk("b2b_WP3", 32'(WP), 32'd3);
    chk("b2b_data3", WriteData, 32'h33);
    step();
    chk("b2b_end", 32'(isWb), 32'd0);

    // Non-writing ALU op produces no pulse.
    send(1'b0, 1'b0, 1'b0, 5'd12, 32'h99, 32'h0);
    idle_inputs();
    chk("nowb_isWb", 32'(isWb), 32'd0);
    step();

`ifdef WB_BYPASS_EN
    send(1'b1, 1'b0, 1'b0, 5'd4, 32'hA, 32'h0);
    idle_inputs();
    RP1 = 5'd4; regA = 32'h0; RP2 = 5'd3; regB = 32'h55;
    #1;
    chk("byp_A", A_fwd, 32'hA);
    chk("byp_B", B_fwd, 32'h55);
    step();
    chk("byp_A_off", A_fwd, 32'h0);
`endif

    // Reset in WAIT_LD discards the load.
    send(1'b1, 1'b1, 1'b0, 5'd10, 32'h0, 32'h0);
    idle_inputs();
    step();
    do_reset();
    chk("midrst_isWb", 32'(isWb), 32'd0);
    chk("midrst_WP", 32'(WP), 32'd0);
    chk("midrst_data", WriteData, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    deliver(32'h1111_2222, 5'd10, 1'b0);
    chk("midrst_ld_ignored", 32'(isWb), 32'd0);
    step();

    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
